uart_tx_8n1: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_gen.sv | 27 ++
 rtl/uart_tx_8n1.sv | 104 ++++++++++
 tb/tb_uart_tx_8n1.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, framing constants and the baud divider calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    START,
    DATA,
    STOP
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / (baud_rate * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: counts 0..BAUD_DIV-1 while enabled, one-clock tick on the last count.
module uart_baud_gen #(
  parameter int BAUD_DIV = 325
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(BAUD_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter with a one-bit idle guard before each start bit.
// Frame occupies 11 bit periods; tx and tx_busy are both registered.
module uart_tx_8n1
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_in,
  input  logic       tx_en,
  output logic       tx,
  output logic       tx_busy
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  state_t     state, state_d;
  logic [3:0] tick_cnt, tick_cnt_d;
  logic [2:0] bit_idx, bit_idx_d;
  logic [7:0] shift, shift_d;
  logic       tx_d, busy_d, accept, running, tick, bit_end;

  assign running = (state != IDLE);
  assign bit_end = tick && (tick_cnt == LAST_TICK);

  // Divider is cleared on acceptance so every bit boundary is frame-aligned.
  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .en   (running),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_d;
      tick_cnt <= tick_cnt_d;
      bit_idx  <= bit_idx_d;
      shift    <= shift_d;
      tx       <= tx_d;
      tx_busy  <= busy_d;
    end
  end

  always_comb begin
    state_d    = state;
    tick_cnt_d = tick_cnt;
    bit_idx_d  = bit_idx;
    shift_d    = shift;
    accept     = 1'b0;

    if (state == IDLE) begin
      if (tx_en) begin
        accept     = 1'b1;
        state_d    = LEAD;
        shift_d    = tx_in;
        tick_cnt_d = '0;
        bit_idx_d  = '0;
      end
    end else if (tick) begin
      tick_cnt_d = tick_cnt + 4'd1;
      if (bit_end) begin
        case (state)
          LEAD:  state_d = START;
          START: state_d = DATA;
          DATA: begin
            shift_d = shift >> 1;
            if (bit_idx == LAST_BIT) begin
              state_d = STOP;
            end else begin
              bit_idx_d = bit_idx + 3'd1;
            end
          end
          STOP:    state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Line level is derived from the state being entered so it lands on the same edge.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Self-checking bench for uart_tx_8n1 using a bit-period line model and randomized bytes.
module tb_uart_tx_8n1;

  localparam int CLK_FREQ  = 480;
  localparam int BAUD_RATE = 10;
  localparam int B         = (CLK_FREQ / (BAUD_RATE * 16)) * 16;
  localparam int FRAME     = 11 * B;

  logic       clk;
  logic       reset;
  logic [7:0] tx_in;
  logic       tx_en;
  logic       tx;
  logic       tx_busy;

  int tests;
  int fails;

  uart_tx_8n1 #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .tx_in  (tx_in),
    .tx_en  (tx_en),
    .tx     (tx),
    .tx_busy(tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level t clocks after acceptance: guard, start, 8 data LSB first, stop.
  function automatic logic exp_line(input logic [7:0] b, input int t);
    int k;
    k = t / B;
    if (k == 0) return 1'b1;
    if (k == 1) return 1'b0;
    if (k <= 9) return b[k-2];
    return 1'b1;
  endfunction

  // Starts at a falling edge, requests a frame, scans every clock of it and the edge after.
  task automatic run_frame(input logic [7:0] b, input int hold, input bit do_swap,
                           input logic [7:0] swap_val, input string name);
    int bad[11];
    int busy_bad;
    int k;
    logic [7:0] rx;
    busy_bad = 0;
    rx = '0;
    for (int i = 0; i < 11; i++) bad[i] = 0;
    tx_in = b;
    tx_en = 1'b1;
    @(posedge clk);
    for (int t = 0; t < FRAME; t++) begin
      @(negedge clk);
      k = t / B;
      if (tx !== exp_line(b, t)) bad[k]++;
      if (tx_busy !== 1'b1) busy_bad++;
      if (k >= 2 && k <= 9 && (t % B) == B / 2) rx[k-2] = tx;
      if (do_swap && t == 0) tx_in = swap_val;
      if (t == hold - 1) tx_en = 1'b0;
    end
    for (int i = 0; i < 11; i++) begin
      tests++;
      if (bad[i] != 0) begin
        fails++;
        $display("FAIL %s bit%0d: tx wrong on %0d of %0d clocks, required %0b",
                 name, i, bad[i], B, exp_line(b, i * B));
      end
    end
    tests++;
    if (rx !== b) begin
      fails++;
      $display("FAIL %s mid-bit data: got %02h, required %02h", name, rx, b);
    end
    tests++;
    if (busy_bad != 0) begin
      fails++;
      $display("FAIL %s busy: low on %0d of %0d frame clocks, required 0", name, busy_bad, FRAME);
    end
    @(negedge clk);
    tests++;
    if (tx_busy !== 1'b0 || tx !== 1'b1) begin
      fails++;
      $display("FAIL %s end: busy=%0b tx=%0b at E+11B, required busy=0 tx=1", name, tx_busy, tx);
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    reset = 1'b1;
    tx_en = 1'b1;
    tx_in = 8'hA5;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset hold: %0d clocks not idle, required 0", bad);
    end
    reset = 1'b0;
    tx_en = 1'b0;
    @(negedge clk);
    tests++;
    if (tx !== 1'b1) begin
      fails++;
      $display("FAIL reset release tx: got %0b, required 1", tx);
    end
    tests++;
    if (tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset release busy: got %0b, required 0", tx_busy);
    end
  endtask

  task automatic test_single_and_follow();
    int bad;
    bad = 0;
    run_frame(8'h55, B, 1'b0, 8'h00, "f55");
    run_frame(8'hAA, B, 1'b0, 8'h00, "fAA");
    for (int i = 0; i < 2 * B; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL idle after frame: %0d clocks not idle, required 0", bad);
    end
  endtask

  task automatic test_input_change();
    run_frame(8'h0F, 1, 1'b1, 8'hF0, "latch");
  endtask

  task automatic test_back_to_back();
    run_frame(8'h3C, FRAME + 10, 1'b0, 8'h00, "b2b0");
    run_frame(8'h3C, FRAME + 10, 1'b0, 8'h00, "b2b1");
    tx_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] b;
    int hold;
    int gap;
    for (int n = 0; n < 6; n++) begin
      b    = 8'($urandom);
      hold = int'($urandom_range(1, FRAME));
      gap  = int'($urandom_range(0, 4));
      run_frame(b, hold, 1'b1, 8'($urandom), "rand");
      for (int g = 0; g < gap; g++) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int bad;
    bad = 0;
    b = 8'($urandom);
    tx_in = b;
    tx_en = 1'b1;
    @(posedge clk);
    for (int t = 0; t < 5 * B; t++) begin
      @(negedge clk);
      if (tx !== exp_line(b, t) || tx_busy !== 1'b1) bad++;
      if (t == 0) tx_en = 1'b0;
      if (t == 5 * B - 1) reset = 1'b1;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL pre-abort frame: %0d clocks wrong, required 0", bad);
    end
    @(negedge clk);
    tests++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL abort: tx=%0b busy=%0b, required tx=1 busy=0", tx, tx_busy);
    end
    reset = 1'b0;
    run_frame(8'($urandom), B, 1'b0, 8'h00, "post-abort");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    tx_en = 1'b0;
    tx_in = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_and_follow();
    test_input_change();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
